// File: rtl/ctrl_pkg.sv
// Shared types and encodings for the multicycle RV32I controller and datapath muxes.
// The state enum, opcode classes and mux select codes live here so both sides agree.
package ctrl_pkg;

  typedef enum logic [2:0] {
    S_FETCH,
    S_DECODE,
    S_EXEC,
    S_MEM,
    S_WB,
    S_HALT
  } state_e;

  typedef enum logic [3:0] {
    C_ALU,
    C_ALU_IMM,
    C_LUI,
    C_AUIPC,
    C_LOAD,
    C_STORE,
    C_BRANCH,
    C_JAL,
    C_JALR,
    C_ILLEGAL
  } opclass_e;

  // RV32I major opcodes (instr[6:0])
  localparam logic [6:0] OPC_LOAD   = 7'b0000011;
  localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
  localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
  localparam logic [6:0] OPC_STORE  = 7'b0100011;
  localparam logic [6:0] OPC_OP     = 7'b0110011;
  localparam logic [6:0] OPC_LUI    = 7'b0110111;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;
  localparam logic [6:0] OPC_JALR   = 7'b1100111;
  localparam logic [6:0] OPC_JAL    = 7'b1101111;

  localparam logic [1:0] WB_ALU = 2'd0;
  localparam logic [1:0] WB_MEM = 2'd1;
  localparam logic [1:0] WB_PC4 = 2'd2;

  localparam logic [1:0] PC_PLUS4  = 2'd0;
  localparam logic [1:0] PC_ALUOUT = 2'd1;
  localparam logic [1:0] PC_JALR   = 2'd2;
  localparam logic [1:0] PC_RESET  = 2'd3;

  localparam logic [1:0] A_RS1  = 2'd0;
  localparam logic [1:0] A_PC   = 2'd1;
  localparam logic [1:0] A_ZERO = 2'd2;

  localparam logic B_RS2 = 1'b0;
  localparam logic B_IMM = 1'b1;

  localparam logic ADDR_PC     = 1'b0;
  localparam logic ADDR_ALUOUT = 1'b1;

endpackage

// File: rtl/multicycle_ctrl_if.sv
// Controller <-> datapath/memory bundle: status inputs to the FSM and every
// enable and mux select it drives.
interface multicycle_ctrl_if;
  logic [31:0] instr;
  logic        br_taken;
  logic        mem_ready;
  logic        mem_req;
  logic        mem_we;
  logic        addr_sel;
  logic        ir_we;
  logic [1:0]  alu_a_sel;
  logic        alu_b_sel;
  logic        reg_we;
  logic [1:0]  wb_sel;
  logic        pc_we;
  logic [1:0]  pc_sel;

  modport master (
    input  instr, br_taken, mem_ready,
    output mem_req, mem_we, addr_sel, ir_we, alu_a_sel, alu_b_sel,
           reg_we, wb_sel, pc_we, pc_sel
  );

  modport slave (
    output instr, br_taken, mem_ready,
    input  mem_req, mem_we, addr_sel, ir_we, alu_a_sel, alu_b_sel,
           reg_we, wb_sel, pc_we, pc_sel
  );
endinterface

// File: rtl/opcode_class.sv
// Combinational map from the RV32I major opcode to an instruction class;
// anything not in the supported set is ILLEGAL.
module opcode_class
  import ctrl_pkg::*;
(
  input  logic [6:0] opcode,
  output opclass_e   cls
);

  always_comb begin
    case (opcode)
      OPC_OP:     cls = C_ALU;
      OPC_OP_IMM: cls = C_ALU_IMM;
      OPC_LUI:    cls = C_LUI;
      OPC_AUIPC:  cls = C_AUIPC;
      OPC_LOAD:   cls = C_LOAD;
      OPC_STORE:  cls = C_STORE;
      OPC_BRANCH: cls = C_BRANCH;
      OPC_JAL:    cls = C_JAL;
      OPC_JALR:   cls = C_JALR;
      default:    cls = C_ILLEGAL;
    endcase
  end

endmodule

// File: rtl/multicycle_ctrl.sv
// Multicycle RV32I control FSM: sequences fetch/decode/exec/mem/wb over the
// shared datapath, counts retired instructions and halts on illegal opcodes.
module multicycle_ctrl
  import ctrl_pkg::*;
#(
  parameter bit RESET_PC_WE = 1'b0
) (
  input  logic                clk,
  input  logic                rst_n,
  multicycle_ctrl_if.master   bus,
  output logic [31:0]         instret,
  output logic                halted
);

  state_e      state_q, state_d;
  logic [31:0] instret_q, instret_d;
  logic        halted_q, halted_d;
  logic        first_q, first_d;
  opclass_e    cls;
  logic        retire;

  logic       mem_req, mem_we, addr_sel, ir_we, alu_b_sel, reg_we, pc_we;
  logic [1:0] alu_a_sel, wb_sel, pc_sel;

  logic unused_instr;
  assign unused_instr = ^bus.instr[31:7];

  opcode_class u_opcode_class (
    .opcode (bus.instr[6:0]),
    .cls    (cls)
  );

  // NOTE: every variable gets a default before the case so no path leaves one
  // unassigned; otherwise synthesis infers latches.
  always_comb begin
    state_d   = state_q;
    halted_d  = halted_q;
    first_d   = 1'b0;
    retire    = 1'b0;
    mem_req   = 1'b0;
    mem_we    = 1'b0;
    addr_sel  = ADDR_PC;
    ir_we     = 1'b0;
    alu_a_sel = A_RS1;
    alu_b_sel = B_RS2;
    reg_we    = 1'b0;
    wb_sel    = WB_ALU;
    pc_we     = 1'b0;
    pc_sel    = PC_PLUS4;

    case (state_q)
      S_FETCH: begin
        mem_req  = 1'b1;
        addr_sel = ADDR_PC;
        if (RESET_PC_WE && first_q) begin
          pc_we  = 1'b1;
          pc_sel = PC_RESET;
        end
        if (bus.mem_ready) begin
          ir_we   = 1'b1;
          state_d = S_DECODE;
        end
      end

      // ALUOut latches PC+imm here so branch/JAL targets are ready in EXEC.
      S_DECODE: begin
        alu_a_sel = A_PC;
        alu_b_sel = B_IMM;
        if (cls == C_ILLEGAL) begin
          state_d  = S_HALT;
          halted_d = 1'b1;
        end else begin
          state_d = S_EXEC;
        end
      end

      S_EXEC: begin
        case (cls)
          C_ALU:     state_d = S_WB;
          C_ALU_IMM: begin alu_b_sel = B_IMM; state_d = S_WB; end
          C_LUI:     begin alu_a_sel = A_ZERO; alu_b_sel = B_IMM; state_d = S_WB; end
          C_AUIPC:   begin alu_a_sel = A_PC;   alu_b_sel = B_IMM; state_d = S_WB; end
          C_LOAD,
          C_STORE:   begin alu_b_sel = B_IMM; state_d = S_MEM; end
          C_BRANCH: begin
            pc_we   = 1'b1;
            pc_sel  = bus.br_taken ? PC_ALUOUT : PC_PLUS4;
            retire  = 1'b1;
            state_d = S_FETCH;
          end
          C_JAL: begin
            pc_we   = 1'b1;
            pc_sel  = PC_ALUOUT;
            reg_we  = 1'b1;
            wb_sel  = WB_PC4;
            retire  = 1'b1;
            state_d = S_FETCH;
          end
          C_JALR: begin
            alu_b_sel = B_IMM;
            pc_we     = 1'b1;
            pc_sel    = PC_JALR;
            reg_we    = 1'b1;
            wb_sel    = WB_PC4;
            retire    = 1'b1;
            state_d   = S_FETCH;
          end
          default: state_d = S_HALT;
        endcase
      end

      S_MEM: begin
        mem_req  = 1'b1;
        addr_sel = ADDR_ALUOUT;
        mem_we   = (cls == C_STORE);
        if (bus.mem_ready) begin
          if (cls == C_STORE) begin
            pc_we   = 1'b1;
            pc_sel  = PC_PLUS4;
            retire  = 1'b1;
            state_d = S_FETCH;
          end else begin
            state_d = S_WB;
          end
        end
      end

      S_WB: begin
        reg_we  = 1'b1;
        pc_we   = 1'b1;
        pc_sel  = PC_PLUS4;
        wb_sel  = (cls == C_LOAD) ? WB_MEM : WB_ALU;
        retire  = 1'b1;
        state_d = S_FETCH;
      end

      S_HALT:  state_d = S_HALT;
      default: state_d = S_FETCH;
    endcase

    instret_d = instret_q + {31'd0, retire};
  end

  // NOTE: sequential state uses non-blocking assignments so every flop samples
  // the pre-edge values regardless of statement order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= S_FETCH;
      instret_q <= '0;
      halted_q  <= 1'b0;
      first_q   <= 1'b1;
    end else begin
      state_q   <= state_d;
      instret_q <= instret_d;
      halted_q  <= halted_d;
      first_q   <= first_d;
    end
  end

  // Reset state is FETCH, so outputs are masked by rst_n to keep the bus
  // quiet (including mem_req) for as long as reset is held.
  assign bus.mem_req   = rst_n & mem_req;
  assign bus.mem_we    = rst_n & mem_we;
  assign bus.addr_sel  = rst_n & addr_sel;
  assign bus.ir_we     = rst_n & ir_we;
  assign bus.alu_a_sel = rst_n ? alu_a_sel : A_RS1;
  assign bus.alu_b_sel = rst_n & alu_b_sel;
  assign bus.reg_we    = rst_n & reg_we;
  assign bus.wb_sel    = rst_n ? wb_sel : WB_ALU;
  assign bus.pc_we     = rst_n & pc_we;
  assign bus.pc_sel    = rst_n ? pc_sel : PC_PLUS4;

  assign instret = instret_q;
  assign halted  = halted_q;

endmodule

// File: tb/tb_multicycle_ctrl.sv
// Scoreboard bench for multicycle_ctrl: the driver queues the expected control
// vector for each cycle, the monitor pops and compares at the falling edge.
module tb_multicycle_ctrl;

  typedef struct packed {
    logic        mem_req;
    logic        mem_we;
    logic        addr_sel;
    logic        ir_we;
    logic [1:0]  alu_a;
    logic        alu_b;
    logic        reg_we;
    logic [1:0]  wb_sel;
    logic        pc_we;
    logic [1:0]  pc_sel;
    logic        halted;
    logic [31:0] instret;
  } ctl_t;

  typedef struct {
    string name;
    ctl_t  v;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [31:0] instret;
  logic        halted;

  exp_t        sb[$];
  event        mon_ev;
  int          n_checks = 0;
  int          n_fail   = 0;
  logic [31:0] m_instret;
  logic        m_halted;

  always #5 clk = ~clk;

  multicycle_ctrl_if bus ();

  multicycle_ctrl #(.RESET_PC_WE(1'b0)) dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .bus     (bus),
    .instret (instret),
    .halted  (halted)
  );

  function automatic ctl_t sample();
    ctl_t s;
    s.mem_req  = bus.mem_req;
    s.mem_we   = bus.mem_we;
    s.addr_sel = bus.addr_sel;
    s.ir_we    = bus.ir_we;
    s.alu_a    = bus.alu_a_sel;
    s.alu_b    = bus.alu_b_sel;
    s.reg_we   = bus.reg_we;
    s.wb_sel   = bus.wb_sel;
    s.pc_we    = bus.pc_we;
    s.pc_sel   = bus.pc_sel;
    s.halted   = halted;
    s.instret  = instret;
    return s;
  endfunction

  // Monitor: compares whenever an expectation is pending.
  initial begin
    exp_t e;
    ctl_t a;
    forever begin
      @(negedge clk or mon_ev);
      if (sb.size() > 0) begin
        e = sb.pop_front();
        a = sample();
        n_checks++;
        if (a !== e.v) begin
          n_fail++;
          $display("FAIL %s: got %h expected %h (req we asel irwe a b rwe wb pcwe pcsel halt instret)",
                   e.name, a, e.v);
        end
      end
    end
  end

  function automatic ctl_t base();
    ctl_t v;
    v = '0;
    v.instret = m_instret;
    v.halted  = m_halted;
    return v;
  endfunction

  // Called at posedge+1: apply inputs, queue this cycle's expectation, advance.
  task automatic cycle(input logic rdy, input logic bt, input string n, input ctl_t v);
    bus.mem_ready = rdy;
    bus.br_taken  = bt;
    sb.push_back('{n, v});
    @(posedge clk);
    #1;
  endtask

  task automatic do_fetch(input int waits);
    ctl_t v;
    for (int i = 0; i < waits; i++) begin
      v = base(); v.mem_req = 1'b1;
      cycle(1'b0, 1'b0, "fetch_wait", v);
    end
    v = base(); v.mem_req = 1'b1; v.ir_we = 1'b1;
    cycle(1'b1, 1'b0, "fetch", v);
  endtask

  // mem_ready/br_taken are driven high here to show DECODE ignores them.
  task automatic do_decode();
    ctl_t v;
    v = base(); v.alu_a = 2'd1; v.alu_b = 1'b1;
    cycle(1'b1, 1'b1, "decode", v);
  endtask

  task automatic do_wb(input logic load);
    ctl_t v;
    v = base(); v.reg_we = 1'b1; v.pc_we = 1'b1; v.wb_sel = load ? 2'd1 : 2'd0;
    cycle(1'b0, 1'b0, load ? "wb_load" : "wb_alu", v);
    m_instret++;
  endtask

  task automatic run_alu(input string n, input logic [31:0] ins,
                         input logic [1:0] a, input logic b);
    ctl_t v;
    bus.instr = ins;
    do_fetch(0);
    do_decode();
    v = base(); v.alu_a = a; v.alu_b = b;
    cycle(1'b1, 1'b0, n, v);
    do_wb(1'b0);
  endtask

  task automatic run_ctrl(input string n, input logic [31:0] ins, input logic bt,
                          input logic b, input logic rwe, input logic [1:0] wb,
                          input logic [1:0] psel);
    ctl_t v;
    bus.instr = ins;
    do_fetch(0);
    do_decode();
    v = base(); v.alu_b = b; v.reg_we = rwe; v.wb_sel = wb; v.pc_we = 1'b1; v.pc_sel = psel;
    cycle(1'b0, bt, n, v);
    m_instret++;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish within the time limit");
    $fatal(1, "watchdog");
  end

  initial begin
    ctl_t v;
    rst_n         = 1'b0;
    bus.instr     = '0;
    bus.mem_ready = 1'b0;
    bus.br_taken  = 1'b0;
    m_instret     = '0;
    m_halted      = 1'b0;

    // Reset held: everything quiet, mem_ready high must not matter.
    @(posedge clk); #1;
    v = base(); cycle(1'b1, 1'b0, "reset0", v);
    v = base(); cycle(1'b1, 1'b0, "reset1", v);
    rst_n = 1'b1;

    // add x0,x1,x2: 4 cycles, instret 1 checked in next fetch
    run_alu("exec_add", 32'h0020_8033, 2'd0, 1'b0);

    // lw with 2 fetch waits and 3 mem waits: 10 cycles
    bus.instr = 32'h0010_2083;
    do_fetch(2);
    do_decode();
    v = base(); v.alu_b = 1'b1; cycle(1'b0, 1'b0, "exec_lw", v);
    for (int i = 0; i < 3; i++) begin
      v = base(); v.mem_req = 1'b1; v.addr_sel = 1'b1;
      cycle(1'b0, 1'b0, "mem_wait_lw", v);
    end
    v = base(); v.mem_req = 1'b1; v.addr_sel = 1'b1;
    cycle(1'b1, 1'b0, "mem_lw", v);
    do_wb(1'b1);

    // branches, jumps
    run_ctrl("exec_beq_taken",  32'h0020_8463, 1'b1, 1'b0, 1'b0, 2'd0, 2'd1);
    run_ctrl("exec_beq_not",    32'h0020_8463, 1'b0, 1'b0, 1'b0, 2'd0, 2'd0);
    run_ctrl("exec_jal",        32'h0000_006F, 1'b0, 1'b0, 1'b1, 2'd2, 2'd1);
    run_ctrl("exec_jalr",       32'h0000_8067, 1'b0, 1'b1, 1'b1, 2'd2, 2'd2);

    // remaining ALU-type classes
    run_alu("exec_lui",   32'h0000_10B7, 2'd2, 1'b1);
    run_alu("exec_auipc", 32'h0000_1097, 2'd1, 1'b1);
    run_alu("exec_addi",  32'h0010_0093, 2'd0, 1'b1);

    // sw with zero wait: 4 cycles, retires in MEM
    bus.instr = 32'h0010_2023;
    do_fetch(0);
    do_decode();
    v = base(); v.alu_b = 1'b1; cycle(1'b0, 1'b0, "exec_sw", v);
    v = base(); v.mem_req = 1'b1; v.addr_sel = 1'b1; v.mem_we = 1'b1; v.pc_we = 1'b1;
    cycle(1'b1, 1'b0, "mem_sw", v);
    m_instret++;

    // Counter wrap: force held across one edge so the flop itself takes the value
    force dut.instret_q = 32'hFFFF_FFFF;
    m_instret = 32'hFFFF_FFFF;
    v = base(); v.mem_req = 1'b1;
    cycle(1'b0, 1'b0, "fetch_wait_forced", v);
    release dut.instret_q;
    run_alu("exec_add_wrap", 32'h0020_8033, 2'd0, 1'b0);

    // Store stalled in MEM, then asynchronous reset mid-wait
    bus.instr = 32'h0010_2023;
    do_fetch(0);
    do_decode();
    v = base(); v.alu_b = 1'b1; cycle(1'b0, 1'b0, "exec_sw2", v);
    v = base(); v.mem_req = 1'b1; v.addr_sel = 1'b1; v.mem_we = 1'b1;
    cycle(1'b0, 1'b0, "mem_wait_sw2", v);
    bus.mem_ready = 1'b0;
    #1;
    rst_n = 1'b0;
    m_instret = '0;
    #1;
    v = base();
    sb.push_back('{"async_reset_mid_mem", v});
    -> mon_ev;
    @(posedge clk); #1;
    v = base(); cycle(1'b0, 1'b0, "reset_hold", v);
    rst_n = 1'b1;
    do_fetch(1);

    // Illegal opcode: decode then sticky HALT with inputs toggling
    bus.instr = 32'hFFFF_FFFF;
    do_decode();
    m_halted = 1'b1;
    for (int i = 0; i < 20; i++) begin
      v = base();
      cycle(i[0], ~i[0], "halt", v);
    end

    for (int i = 0; i < 10 && sb.size() > 0; i++) @(negedge clk);
    if (sb.size() > 0) begin
      n_checks++;
      n_fail++;
      $display("FAIL drain: got %0d pending expectations, expected 0", sb.size());
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
